// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-Lite3 multi-cycle controller and datapath.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF, S_DCD, S_EXE_R, S_EXE_I, S_MA, S_MR, S_MW, S_WB_ALU, S_WB_MEM, S_BR
  } state_t;

  typedef enum logic [3:0] {
    C_R_ARITH, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_JR, C_ILLEGAL
  } cls_t;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // funct codes (IR[5:0]) for op 000000
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_JR   = 6'b001000;

  // ALU function select
  localparam logic [2:0] ALU_NONE  = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SLTU  = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero in, strobes and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic       mem_wr;
  logic [1:0] npc_op;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic [1:0] ext_op;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       illegal;

  // controller side
  modport master (
    input  op, funct, zero,
    output pc_wr, ir_wr, reg_wr, mem_wr, npc_op, alu_op, alu_src_b,
           ext_op, reg_dst, mem_to_reg, illegal
  );

  // datapath side
  modport slave (
    output op, funct, zero,
    input  pc_wr, ir_wr, reg_wr, mem_wr, npc_op, alu_op, alu_src_b,
           ext_op, reg_dst, mem_to_reg, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// Instruction classifier: op/funct -> class plus the ALU function used in EXE.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] alu_f
);

  // anything not matched falls through as ILLEGAL with a don't-care ALU code
  always_comb begin
    cls   = C_ILLEGAL;
    alu_f = ALU_NONE;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: begin cls = C_R_ARITH; alu_f = ALU_ADD;  end
          F_SUBU: begin cls = C_R_ARITH; alu_f = ALU_SUB;  end
          F_SLTU: begin cls = C_R_ARITH; alu_f = ALU_SLTU; end
          F_JR:   cls = C_JR;
          default: ;
        endcase
      end
      OP_ORI:  begin cls = C_IMM;    alu_f = ALU_OR;    end
      OP_LUI:  begin cls = C_IMM;    alu_f = ALU_PASSB; end
      OP_LW:   begin cls = C_LOAD;   alu_f = ALU_ADD;   end
      OP_SW:   begin cls = C_STORE;  alu_f = ALU_ADD;   end
      OP_BEQ:  begin cls = C_BRANCH; alu_f = ALU_SUB;   end
      OP_J:    cls = C_JUMP;
      OP_JAL:  cls = C_JAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore controller for MIPS-Lite3 (IF/DCD/EXE/MEM/WB).
// Outputs decode the current state and the IR fields, which stay stable
// from DCD to the next IF; beq's pc_wr follows Zero in the same cycle.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  state_t     state;
  cls_t       cls;
  logic [2:0] alu_f;
  logic       is_lui;

  mc_decode u_dec (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls),
    .alu_f (alu_f)
  );

  assign is_lui = (bus.op == OP_LUI);

  // state sequencing; reset aborts any instruction and restarts at fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF:  state <= S_DCD;
        S_DCD: begin
          case (cls)
            C_R_ARITH:        state <= S_EXE_R;
            C_IMM:            state <= S_EXE_I;
            C_LOAD, C_STORE:  state <= S_MA;
            C_BRANCH:         state <= S_BR;
            default:          state <= S_IF;  // jumps and illegal finish here
          endcase
        end
        S_EXE_R, S_EXE_I: state <= S_WB_ALU;
        S_MA:     state <= (cls == C_LOAD) ? S_MR : S_MW;
        S_MR:     state <= S_WB_MEM;
        default:  state <= S_IF;            // WB_ALU, WB_MEM, MW, BR
      endcase
    end
  end

  // output decode; during reset everything reads as the quiet IF-select pattern
  always_comb begin
    bus.pc_wr      = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.npc_op     = NPC_PC4;
    bus.alu_op     = ALU_NONE;
    bus.alu_src_b  = 1'b0;
    bus.ext_op     = EXT_ZERO;
    bus.reg_dst    = DST_RT;
    bus.mem_to_reg = M2R_ALU;
    bus.illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          bus.pc_wr = 1'b1;
          bus.ir_wr = 1'b1;
        end
        S_DCD: begin
          case (cls)
            C_JUMP: begin
              bus.pc_wr  = 1'b1;
              bus.npc_op = NPC_J;
            end
            C_JAL: begin
              bus.pc_wr      = 1'b1;
              bus.npc_op     = NPC_J;
              bus.reg_wr     = 1'b1;
              bus.reg_dst    = DST_RA;
              bus.mem_to_reg = M2R_PC4;
            end
            C_JR: begin
              bus.pc_wr  = 1'b1;
              bus.npc_op = NPC_JR;
            end
            C_ILLEGAL: bus.illegal = 1'b1;
            default: ;
          endcase
        end
        S_EXE_R: bus.alu_op = alu_f;
        S_EXE_I: begin
          bus.alu_src_b = 1'b1;
          bus.ext_op    = is_lui ? EXT_LUI : EXT_ZERO;
          bus.alu_op    = alu_f;
        end
        S_WB_ALU: begin
          // ALU inputs held so the result stays valid through the write
          bus.reg_wr    = 1'b1;
          bus.alu_op    = alu_f;
          bus.alu_src_b = (cls == C_IMM);
          bus.ext_op    = (cls == C_IMM && is_lui) ? EXT_LUI : EXT_ZERO;
          bus.reg_dst   = (cls == C_R_ARITH) ? DST_RD : DST_RT;
        end
        S_MA, S_MR, S_MW: begin
          // address computation held across the memory cycles
          bus.alu_src_b = 1'b1;
          bus.ext_op    = EXT_SIGN;
          bus.alu_op    = ALU_ADD;
          bus.mem_wr    = (state == S_MW);
        end
        S_WB_MEM: begin
          bus.reg_wr     = 1'b1;
          bus.mem_to_reg = M2R_MDR;
        end
        S_BR: begin
          bus.alu_op = ALU_SUB;
          bus.npc_op = NPC_BR;
          bus.ext_op = EXT_SIGN;
          bus.pc_wr  = bus.zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-Lite3 core: a Moore state machine that decodes the instruction in IR and sequences PC, IR, register file, data memory, extender, next-PC logic and the 3-bit-function ALU across IF / DCD / EXE / MEM / WB cycles. It sits beside the datapath, taking only opcode, funct and the ALU `Zero` flag back in, and drives every write strobe and mux select.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU Zero flag, combinational from the current ALU result.
- `pc_wr`  out  1  PC load strobe.
- `ir_wr`  out  1  IR load strobe.
- `reg_wr`  out  1  register-file write strobe.
- `mem_wr`  out  1  data-memory write strobe.
- `npc_op`  out  2  00 PC+4, 01 branch target, 10 jump target {PC[31:28],imm26,00}, 11 rs (jr).
- `alu_op`  out  3  ALU F: 001 OR, 010 SUB, 011 ADD, 100 unsigned less-than, 101 pass B.
- `alu_src_b`  out  1  0 register B, 1 extended immediate.
- `ext_op`  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31.
- `mem_to_reg`  out  2  00 ALU result, 01 memory data register, 10 PC+4.
- `illegal`  out  1  one-cycle pulse in DCD for an unsupported encoding.

## Operation
- Supported: addu, subu, sltu, jr (op 000000; funct 100001/100011/101011/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: IF, DCD, EXE_R, EXE_I, MA, MR, MW, WB_ALU, WB_MEM, BR.
- IF: pc_wr=1, ir_wr=1, npc_op=00 -> DCD.
- DCD: decode only (A/B registers load in datapath).
  - R-arith -> EXE_R; ori/lui -> EXE_I; lw/sw -> MA; beq -> BR.
  - j: pc_wr=1, npc_op=10 -> IF.
  - jal: pc_wr=1, npc_op=10, reg_wr=1, reg_dst=10, mem_to_reg=10 -> IF.
  - jr: pc_wr=1, npc_op=11 -> IF.
  - Unsupported: illegal=1, no strobes -> IF (executes as nop).
- EXE_R: alu_src_b=0, alu_op 011/010/100 for addu/subu/sltu -> WB_ALU.
- EXE_I: alu_src_b=1; ori: ext_op=00, alu_op=001; lui: ext_op=10, alu_op=101 -> WB_ALU.
- WB_ALU: reg_wr=1, mem_to_reg=00, reg_dst=01 (R-type) or 00 (I-type); alu_op/alu_src_b/ext_op held from EXE -> IF.
- MA: alu_src_b=1, ext_op=01, alu_op=011 -> MR (lw) or MW (sw).
- MR: address held (same ALU controls) -> WB_MEM.
- MW: mem_wr=1, address held -> IF.
- WB_MEM: reg_wr=1, reg_dst=00, mem_to_reg=01 -> IF.
- BR: alu_src_b=0, alu_op=010, npc_op=01, ext_op=01, pc_wr=zero -> IF.
- All outputs are combinational decodes of state plus latched op/funct; any output not listed for a state is 0. op/funct decode uses IR, which is stable from DCD until the next IF.

## Timing
- CPI: j/jal/jr 2; beq 3; addu/subu/sltu/ori/lui/sw 4; lw 5; illegal 2.
- On a rising edge with rst=1, state <= IF. While rst=1, pc_wr, ir_wr, reg_wr, mem_wr are forced to 0 and illegal=0; the mux selects show their IF values (all 0). The first fetch strobe occurs in the first cycle after rst deasserts.
- rst asserted mid-instruction aborts it: no strobe fires in the reset cycle; the partial result is discarded.
- At most one of reg_wr / mem_wr is high in any cycle. pc_wr is never high outside IF, DCD (jump class) and BR.
- In BR, zero is sampled in the same cycle, with no registering. A not-taken beq leaves PC at PC+4, which was already loaded in IF.

## Structure
- `mc_pkg`: state enum, opcode/funct constants, ALU F codes, npc_op / ext_op / reg_dst / mem_to_reg encodings. The ALU and datapath muxes import the same constants.
- Sub-module `mc_decode`: combinational op/funct -> instruction class (R_ARITH, IMM, LOAD, STORE, BRANCH, JUMP, JAL, JR, ILLEGAL) plus the EXE alu_op. The FSM in `mc_ctrl` consumes only the class.

## Test plan
- Reset: hold rst 3 cycles -> all strobes 0. Release -> cycle 1 in IF with pc_wr=ir_wr=1.
- addu (op 0, funct 100001) -> states IF,DCD,EXE_R,WB_ALU. alu_op=011 in EXE_R/WB_ALU. reg_wr=1, reg_dst=01 only in WB_ALU. Next IF on cycle 5.
- lw then sw -> lw: 5 cycles, reg_wr only in WB_MEM with mem_to_reg=01. sw: 4 cycles, mem_wr=1 only in MW, ext_op=01, alu_op=011.
- beq with zero=1, then with zero=0 -> BR pc_wr=1 with npc_op=01 in the first case, pc_wr=0 in the second. Both cases return to IF after 3 cycles.
- jal, then jr -> jal: DCD has pc_wr=1, npc_op=10, reg_wr=1, reg_dst=10, mem_to_reg=10. jr: DCD has npc_op=11. Each instruction takes 2 cycles.
- op=111111 -> illegal=1 for one cycle in DCD, no strobes, IF next. rst pulsed during MW of an sw -> mem_wr=0 that cycle, IF next.
